// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-side bundle between the PC/fetch controller and its surroundings:
// stall/redirect inputs, memory handshake and the fetch address outputs.
interface pc_fetch_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             stall;
  logic             addr_ok;
  logic             exc_valid;
  logic [WIDTH-1:0] exc_target;
  logic             eret_valid;
  logic [WIDTH-1:0] eret_target;
  logic             br_valid;
  logic [WIDTH-1:0] br_target;
  logic [WIDTH-1:0] pc;
  logic             req;
  logic             started;
  logic             addr_err;
  logic             redirect_pending;

  modport master (
    input  stall, addr_ok,
    input  exc_valid, exc_target,
    input  eret_valid, eret_target,
    input  br_valid, br_target,
    output pc, req, started, addr_err, redirect_pending
  );

  modport slave (
    output stall, addr_ok,
    output exc_valid, exc_target,
    output eret_valid, eret_target,
    output br_valid, br_target,
    input  pc, req, started, addr_err, redirect_pending
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch-request generator: boots from RESET_VECTOR, applies
// prioritised redirects and buffers one redirect while a request is unaccepted.
module pc_fetch_ctrl #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 32'hBFC00000,
  parameter int               STEP         = 4,
  parameter int               ALIGN_BITS   = 2
) (
  input logic             clk,
  input logic             rst,
  pc_fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;
  // Ordered so that a numerically larger class wins arbitration.
  typedef enum logic [1:0] {CLS_NONE, CLS_BR, CLS_ERET, CLS_EXC} cls_t;

  state_t           state_q, state_d;
  cls_t             pend_class_q, pend_class_d;
  cls_t             cur_class, sel_class;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pend_target_q, pend_target_d;
  logic [WIDTH-1:0] cur_target, sel_target;
  logic             started_q, started_d;
  logic             pending, addr_err, req, accept, locked, sel_valid;

  assign pending  = (state_q == HOLD);
  assign addr_err = started_q & (pc_q[ALIGN_BITS-1:0] != '0);
  assign req      = started_q & ~bus.stall & ~addr_err;
  assign accept   = req & bus.addr_ok;
  assign locked   = req & ~bus.addr_ok;

  always_comb begin
    cur_class  = CLS_NONE;
    cur_target = '0;
    if (bus.exc_valid) begin
      cur_class  = CLS_EXC;
      cur_target = bus.exc_target;
    end else if (bus.eret_valid) begin
      cur_class  = CLS_ERET;
      cur_target = bus.eret_target;
    end else if (bus.br_valid) begin
      cur_class  = CLS_BR;
      cur_target = bus.br_target;
    end

    // The buffered redirect only wins over a strictly lower current class.
    sel_class  = cur_class;
    sel_target = cur_target;
    if (pending && (pend_class_q > cur_class)) begin
      sel_class  = pend_class_q;
      sel_target = pend_target_q;
    end
    sel_valid = (sel_class != CLS_NONE);
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    started_d     = started_q;
    pend_class_d  = pend_class_q;
    pend_target_d = pend_target_q;
    case (state_q)
      BOOT: begin
        state_d   = RUN;
        started_d = 1'b1;
      end
      RUN, HOLD: begin
        if (!locked) begin
          if (sel_valid) begin
            pc_d         = sel_target;
            pend_class_d = CLS_NONE;
            state_d      = RUN;
          end else if (accept) begin
            pc_d = pc_q + WIDTH'(STEP);
          end
        end else if (cur_class != CLS_NONE) begin
          pend_class_d  = sel_class;
          pend_target_d = sel_target;
          state_d       = HOLD;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_VECTOR;
      started_q     <= 1'b0;
      pend_class_q  <= CLS_NONE;
      pend_target_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      started_q     <= started_d;
      pend_class_q  <= pend_class_d;
      pend_target_q <= pend_target_d;
    end
  end

  assign bus.pc               = pc_q;
  assign bus.req              = req;
  assign bus.started          = started_q;
  assign bus.addr_err         = addr_err;
  assign bus.redirect_pending = pending;

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Parametrised program-counter and fetch-request generator for the MIPS core front end.
- Boots from a configurable reset vector and issues fetch addresses over an SRAM-like req/addr_ok handshake.
- Applies prioritised redirects for exception, eret and branch.
- Buffers one redirect while an issued address is waiting for acceptance, so the address stays stable.
- Flags misaligned PCs for the exception unit.

Parameters:
- WIDTH, 32, PC/address width in bits.
- RESET_VECTOR, 32'hBFC00000, PC value loaded by reset.
- STEP, 4, sequential increment per accepted fetch.
- ALIGN_BITS, 2, number of low PC bits that must be zero.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  pipeline stall; suppresses new fetch requests.
- addr_ok  in  1  memory accepted the current request this cycle.
- exc_valid  in  1  exception redirect request.
- exc_target  in  WIDTH  exception handler address.
- eret_valid  in  1  eret redirect request.
- eret_target  in  WIDTH  EPC value.
- br_valid  in  1  branch/jump redirect request.
- br_target  in  WIDTH  branch/jump target.
- pc  out  WIDTH  current fetch address.
- req  out  1  fetch request valid.
- started  out  1  high from the first cycle after boot onward.
- addr_err  out  1  pc low ALIGN_BITS non-zero.
- redirect_pending  out  1  a buffered redirect is held.

Behaviour:
- Reset: rst=1 at a clk edge sets pc=RESET_VECTOR, started=0, pending=0, state=BOOT. While in BOOT: req=0, addr_err=0, redirect_pending=0. rst overrides every other input, including mid-handshake and with a redirect pending.
- States:
  - BOOT: lasts exactly one cycle, then RUN; started becomes 1 at that same edge and stays 1 until the next reset.
  - RUN: pending=0.
  - HOLD: pending=1.
  - In every state except BOOT, redirect_pending equals pending.
- Request generation:
  - req = started & ~stall & ~addr_err (combinational).
  - accept = req & addr_ok.
  - "Locked" means req=1 & addr_ok=0. While locked, pc must not change.
- Redirect selection:
  - The candidates are exc_valid, eret_valid and br_valid in the current cycle, plus the buffered pending redirect.
  - Priority is exc > eret > br.
  - A pending redirect competes at its stored priority class. On equal class, the current-cycle input wins over the pending one.
  - sel_valid / sel_target denote the winner.
- pc update at each edge in RUN/HOLD:
  - If not locked and sel_valid: pc <= sel_target, pending <= 0, next state RUN. This covers accept, stall and addr_err.
  - If not locked, no sel_valid, and accept: pc <= pc + STEP, modulo 2^WIDTH.
  - If not locked, no sel_valid, and no accept: pc holds.
  - If locked and any current-cycle redirect: pending register <= sel_target and its class, next state HOLD. A higher-priority or equal-class newer redirect overwrites the buffer; a lower class is dropped.
  - If locked with no new redirect: hold everything.
- addr_err:
  - addr_err = started & (pc[ALIGN_BITS-1:0] != 0).
  - It forces req=0, so the PC never issues a misaligned fetch.
  - The exception unit clears the condition by asserting exc_valid; the exc_target is taken at the next edge.
  - No sequential advance occurs while addr_err=1.
- Targets are not realigned by this block. The delay-slot policy belongs upstream: this block redirects exactly when told.
- Redirects asserted in BOOT are ignored.

Test Plan:
- Reset then free run: rst=1 for 2 cycles, addr_ok=1 -> pc=0xBFC00000, req=0 for one BOOT cycle, then started=1, req=1 and pc sequence BFC00000, BFC00004, BFC00008.
- Handshake hold: addr_ok=0 for 3 cycles at pc=0xBFC00010, br_valid=1 with br_target=0xBFC00100 in the first of them -> pc stays BFC00010 and redirect_pending=1. On the cycle addr_ok=1 the next pc=0xBFC00100 and redirect_pending=0.
- Priority: br_valid and exc_valid (exc_target=0xBFC00380) in the same unlocked cycle -> pc=0xBFC00380. Pending branch then locked exc -> buffer replaced, pc later 0xBFC00380. Pending exc then locked branch -> branch dropped.
- Stall: stall=1 at pc=0xBFC00020 -> req=0 and pc holds. eret_valid=1 with eret_target=0x80001000 during the stall -> pc=0x80001000 next edge with no pending; after stall drops, fetch proceeds from 0x80001000.
- Misalignment: br_target=0x80000002 accepted -> addr_err=1 and req=0 with pc stuck. exc_valid with exc_target=0xBFC00380 -> pc=0xBFC00380, addr_err=0, req=1.
- Reset mid-operation: rst=1 while HOLD with a pending redirect -> next cycle pc=0xBFC00000, redirect_pending=0, started=0, req=0. Also cover the wrap case: pc=0xFFFFFFFC plus accept -> pc=0x00000000.
